// File: rtl/apu_pkg.sv
// Shared types and helpers for the APU pulse cores: period/duty types,
// NES duty codes, the decoder FSM states and the duty quantiser.
package apu_pkg;

    typedef logic [10:0] period_t;
    typedef logic [1:0]  duty_t;

    localparam duty_t DUTY_12 = 2'd0;
    localparam duty_t DUTY_25 = 2'd1;
    localparam duty_t DUTY_50 = 2'd2;
    localparam duty_t DUTY_75 = 2'd3;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        HIGH    = 2'd1,
        LOW     = 2'd2
    } state_t;

    // Map a high-time / period ratio onto the nearest NES duty code.
    // Thresholds sit between the nominal ratios (1/8, 1/4, 1/2, 3/4) and are
    // evaluated as 16*h against 3p, 6p and 10p in 16-bit unsigned arithmetic,
    // which holds 10 * 2047 without overflow.
    function automatic duty_t quantise_duty(input period_t per, input period_t hi);
        logic [15:0] h16;
        logic [15:0] p16;
        h16 = {1'b0, hi, 4'b0000};
        p16 = {5'b00000, per};
        if (h16 < p16 * 16'd3) begin
            return DUTY_12;
        end else if (h16 < p16 * 16'd6) begin
            return DUTY_25;
        end else if (h16 < p16 * 16'd10) begin
            return DUTY_50;
        end else begin
            return DUTY_75;
        end
    endfunction

endpackage

// File: rtl/apu_schmitt.sv
// Hysteresis level tracker for the pulse decoder. The level only moves on
// valid samples that clear +HYST (goes high) or -HYST (goes low); samples
// inside the band hold it. rise/fall flag the valid sample that causes the
// transition, in the same cycle that sample is presented.
module apu_schmitt #(
    parameter int W    = 16,
    parameter int HYST = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                level,
    output logic                rise,
    output logic                fall
);

    localparam logic signed [W-1:0] HI_TH = W'(HYST);
    localparam logic signed [W-1:0] LO_TH = W'(-HYST);

    logic level_q;
    logic level_d;

    // Next level from the current sample, plus edge flags for this sample.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        level_d = level_q;
        if (sample_valid) begin
            if (sample_in > HI_TH) begin
                level_d = 1'b1;
            end else if (sample_in < LO_TH) begin
                level_d = 1'b0;
            end
        end
        rise = level_d & ~level_q;
        fall = ~level_d & level_q;
    end

    // Level register.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/apu_pulse_decoder.sv
// APU pulse decoder: measures a square wave on a signed sample stream and
// reports its period (in samples) and NES duty code on a valid/ready channel
// that mirrors the pulse generator's period/duty inputs.
// Optional build macro APU_PULSE_DECODER_AVG_EN: when defined, the reported
// period is the rounded mean of this and the previous non-silence period.
module apu_pulse_decoder
    import apu_pkg::*;
#(
    parameter int W          = 16,
    parameter int HYST       = 1024,
    parameter int PERIOD_MAX = 2047
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [10:0]         period_out,
    output logic [1:0]          duty_out,
    output logic                meas_vld,
    input  logic                meas_rdy,
    output logic                overrun
);

    localparam period_t PMAX = period_t'(PERIOD_MAX);

    logic    level;
    logic    rise;
    logic    fall;

    state_t  state_q, state_d;
    period_t per_q, per_d;
    period_t hi_q, hi_d;
    period_t period_q, period_d;
    duty_t   duty_q, duty_d;
    logic    vld_q, vld_d;
    logic    ovr_q, ovr_d;

    logic    per_at_max;
    logic    emit_meas;
    logic    emit_silence;
    duty_t   cur_duty;
    period_t cur_period;

`ifdef APU_PULSE_DECODER_AVG_EN
    period_t     prev_q, prev_d;
    logic        prev_vld_q, prev_vld_d;
    logic [11:0] avg_sum;
`endif

    apu_schmitt #(
        .W    (W),
        .HYST (HYST)
    ) u_schmitt (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .level        (level),
        .rise         (rise),
        .fall         (fall)
    );

    assign per_at_max = (per_q >= PMAX);

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACQUIRE;
            per_q      <= '0;
            hi_q       <= '0;
            period_q   <= '0;
            duty_q     <= DUTY_12;
            vld_q      <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef APU_PULSE_DECODER_AVG_EN
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            per_q      <= per_d;
            hi_q       <= hi_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            vld_q      <= vld_d;
            ovr_q      <= ovr_d;
`ifdef APU_PULSE_DECODER_AVG_EN
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
`endif
        end
    end

    // Next state and counters; everything holds on samples that are not valid.
    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        hi_d    = hi_q;
        if (sample_valid) begin
            case (state_q)
                ACQUIRE: begin
                    if (rise) begin
                        per_d   = 11'd1;
                        hi_d    = 11'd1;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (per_at_max) begin
                        state_d = ACQUIRE;
                    end else begin
                        per_d = per_q + 11'd1;
                        // hi_cnt only counts samples that leave the level high.
                        if (level && !fall) begin
                            hi_d = hi_q + 11'd1;
                        end
                        if (fall) begin
                            state_d = LOW;
                        end
                    end
                end
                LOW: begin
                    // The rising sample closes this period and opens the next.
                    if (rise) begin
                        per_d   = 11'd1;
                        hi_d    = 11'd1;
                        state_d = HIGH;
                    end else if (per_at_max) begin
                        state_d = ACQUIRE;
                    end else begin
                        per_d = per_q + 11'd1;
                    end
                end
                default: state_d = ACQUIRE;
            endcase
        end
    end

    // Emission decode, duty quantiser and the valid/ready output register.
    always_comb begin
        emit_meas    = sample_valid & rise & (state_q == LOW);
        emit_silence = sample_valid & per_at_max &
                       ((state_q == HIGH) | ((state_q == LOW) & ~rise));
        cur_duty     = quantise_duty(per_q, hi_q);

`ifdef APU_PULSE_DECODER_AVG_EN
        avg_sum    = {1'b0, prev_q} + {1'b0, per_q} + 12'd1;
        cur_period = prev_vld_q ? avg_sum[11:1] : per_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        if (emit_meas) begin
            prev_d     = per_q;
            prev_vld_d = 1'b1;
        end else if (emit_silence) begin
            prev_vld_d = 1'b0;
        end
`else
        cur_period = per_q;
`endif

        period_d = period_q;
        duty_d   = duty_q;
        vld_d    = vld_q & ~meas_rdy;
        ovr_d    = ovr_q;
        if (emit_meas || emit_silence) begin
            vld_d    = 1'b1;
            // Replacing data the consumer never took is sticky until reset.
            ovr_d    = ovr_q | (vld_q & ~meas_rdy);
            period_d = emit_silence ? '0 : cur_period;
            duty_d   = emit_silence ? DUTY_12 : cur_duty;
        end
    end

    assign period_out = period_q;
    assign duty_out   = duty_q;
    assign meas_vld   = vld_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_apu_pulse_decoder.sv
// Directed bench for apu_pulse_decoder: duty patterns, hysteresis band,
// gaps in sample_valid, timeout, overrun handshake and the optional
// period averaging (APU_PULSE_DECODER_AVG_EN).
module tb_apu_pulse_decoder;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [W-1:0] sample_in = '0;
    logic                sample_valid = 1'b0;
    logic                meas_rdy = 1'b1;
    logic [10:0]         period_out;
    logic [1:0]          duty_out;
    logic                meas_vld;
    logic                overrun;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [10:0] p;
        logic [1:0]  d;
    } emit_t;

    emit_t cap_q[$];

    apu_pulse_decoder #(
        .W          (W),
        .HYST       (1024),
        .PERIOD_MAX (2047)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .period_out   (period_out),
        .duty_out     (duty_out),
        .meas_vld     (meas_vld),
        .meas_rdy     (meas_rdy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Record every accepted measurement, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && meas_vld && meas_rdy) begin
            cap_q.push_back({period_out, duty_out});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic send(input int val, input int n);
        for (int i = 0; i < n; i++) begin
            sample_in    = W'(val);
            sample_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
    endtask

    // Each valid sample is followed by an invalid cycle carrying the opposite value.
    task automatic send_gappy(input int val, input int n);
        for (int i = 0; i < n; i++) begin
            sample_in    = W'(val);
            sample_valid = 1'b1;
            @(posedge clk);
            #1;
            sample_in    = W'(-val);
            sample_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        sample_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        cap_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (period_out !== 11'd0) begin fails++; $display("FAIL reset_period: got %0d expected 0", period_out); end
        checks++;
        if (duty_out !== 2'd0) begin fails++; $display("FAIL reset_duty: got %0d expected 0", duty_out); end
        checks++;
        if (meas_vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %0b expected 0", meas_vld); end
        checks++;
        if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    endtask

    task automatic test_duty();
        int hi_t[4]  = '{4, 8, 12, 2};
        int exp_d[4] = '{1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            meas_rdy = 1'b1;
            repeat (3) begin
                send(16000, hi_t[k]);
                send(-16000, 16 - hi_t[k]);
            end
            send(16000, 1);
            idle(2);
            checks++;
            if (cap_q.size() != 3) begin
                fails++;
                $display("FAIL duty%0d_count: got %0d emits expected 3", hi_t[k], cap_q.size());
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (i >= cap_q.size()) begin
                    fails++;
                    $display("FAIL duty%0d_emit%0d: missing, expected period 16 duty %0d", hi_t[k], i, exp_d[k]);
                end else if (cap_q[i].p !== 11'd16 || cap_q[i].d !== 2'(exp_d[k])) begin
                    fails++;
                    $display("FAIL duty%0d_emit%0d: got period %0d duty %0d expected period 16 duty %0d",
                             hi_t[k], i, cap_q[i].p, cap_q[i].d, exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_hysteresis();
        do_reset();
        meas_rdy = 1'b1;
        repeat (10) begin
            send(512, 1);
            send(-512, 1);
            send(1024, 1);
            send(-1024, 1);
        end
        idle(2);
        checks++;
        if (cap_q.size() != 0) begin
            fails++;
            $display("FAIL hyst_inband: got %0d emits expected 0", cap_q.size());
        end
        // In-band samples after a crossing must hold the level.
        repeat (2) begin
            send(2000, 5);
            send(1024, 5);
            send(-2000, 5);
            send(-1024, 5);
        end
        send(2000, 1);
        idle(2);
        checks++;
        if (cap_q.size() != 2) begin
            fails++;
            $display("FAIL hyst_count: got %0d emits expected 2", cap_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= cap_q.size()) begin
                fails++;
                $display("FAIL hyst_emit%0d: missing, expected period 20 duty 2", i);
            end else if (cap_q[i].p !== 11'd20 || cap_q[i].d !== 2'd2) begin
                fails++;
                $display("FAIL hyst_emit%0d: got period %0d duty %0d expected period 20 duty 2",
                         i, cap_q[i].p, cap_q[i].d);
            end
        end
    endtask

    task automatic test_valid_gaps();
        do_reset();
        meas_rdy = 1'b1;
        repeat (2) begin
            send_gappy(16000, 10);
            send_gappy(-16000, 10);
        end
        send(16000, 1);
        idle(2);
        checks++;
        if (cap_q.size() != 2) begin
            fails++;
            $display("FAIL gaps_count: got %0d emits expected 2", cap_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= cap_q.size()) begin
                fails++;
                $display("FAIL gaps_emit%0d: missing, expected period 20 duty 2", i);
            end else if (cap_q[i].p !== 11'd20 || cap_q[i].d !== 2'd2) begin
                fails++;
                $display("FAIL gaps_emit%0d: got period %0d duty %0d expected period 20 duty 2",
                         i, cap_q[i].p, cap_q[i].d);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        meas_rdy = 1'b1;
        send(-16000, 3);
        // Rising sample counts 1; 2047 high samples bring the count exactly to the limit.
        send(16000, 2047);
        idle(1);
        checks++;
        if (cap_q.size() != 0) begin
            fails++;
            $display("FAIL timeout_early: got %0d emits expected 0", cap_q.size());
        end
        send(16000, 1);
        idle(1);
        checks++;
        if (cap_q.size() != 1) begin
            fails++;
            $display("FAIL timeout_count: got %0d emits expected 1", cap_q.size());
        end else if (cap_q[0].p !== 11'd0 || cap_q[0].d !== 2'd0) begin
            fails++;
            $display("FAIL timeout_silence: got period %0d duty %0d expected period 0 duty 0",
                     cap_q[0].p, cap_q[0].d);
        end
        send(16000, 100);
        idle(1);
        checks++;
        if (cap_q.size() != 1) begin
            fails++;
            $display("FAIL timeout_once: got %0d emits expected 1", cap_q.size());
        end
        send(-16000, 10);
        send(16000, 10);
        send(-16000, 10);
        send(16000, 1);
        idle(2);
        checks++;
        if (cap_q.size() != 2) begin
            fails++;
            $display("FAIL relock_count: got %0d emits expected 2", cap_q.size());
        end else if (cap_q[1].p !== 11'd20 || cap_q[1].d !== 2'd2) begin
            fails++;
            $display("FAIL relock_emit: got period %0d duty %0d expected period 20 duty 2",
                     cap_q[1].p, cap_q[1].d);
        end
        checks++;
        if (overrun !== 1'b0) begin fails++; $display("FAIL timeout_overrun: got %0b expected 0", overrun); end
    endtask

    task automatic test_overrun();
        do_reset();
        meas_rdy = 1'b0;
        send(16000, 10);
        send(-16000, 10);
        @(negedge clk);
        checks++;
        if (meas_vld !== 1'b0) begin fails++; $display("FAIL ovr_pre_vld: got %0b expected 0", meas_vld); end
        send(16000, 1);
        @(negedge clk);
        checks++;
        if (meas_vld !== 1'b1) begin fails++; $display("FAIL ovr_latency_vld: got %0b expected 1", meas_vld); end
        checks++;
        if (period_out !== 11'd20 || duty_out !== 2'd2) begin
            fails++;
            $display("FAIL ovr_first: got period %0d duty %0d expected period 20 duty 2", period_out, duty_out);
        end
        checks++;
        if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_first_flag: got %0b expected 0", overrun); end
        send(16000, 14);
        send(-16000, 5);
        @(negedge clk);
        checks++;
        if (meas_vld !== 1'b1 || period_out !== 11'd20 || duty_out !== 2'd2) begin
            fails++;
            $display("FAIL ovr_hold: got vld %0b period %0d duty %0d expected vld 1 period 20 duty 2",
                     meas_vld, period_out, duty_out);
        end
        send(16000, 1);
        @(negedge clk);
        checks++;
        if (meas_vld !== 1'b1 || period_out !== 11'd20 || duty_out !== 2'd3) begin
            fails++;
            $display("FAIL ovr_second: got vld %0b period %0d duty %0d expected vld 1 period 20 duty 3",
                     meas_vld, period_out, duty_out);
        end
        checks++;
        if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %0b expected 1", overrun); end
        meas_rdy = 1'b1;
        @(posedge clk);
        #1;
        meas_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (meas_vld !== 1'b0) begin fails++; $display("FAIL ovr_accept_vld: got %0b expected 0", meas_vld); end
        checks++;
        if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %0b expected 1", overrun); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0 || meas_vld !== 1'b0 || period_out !== 11'd0) begin
            fails++;
            $display("FAIL ovr_reset: got overrun %0b vld %0b period %0d expected 0 0 0",
                     overrun, meas_vld, period_out);
        end
        meas_rdy = 1'b1;
    endtask

    task automatic test_avg();
`ifdef APU_PULSE_DECODER_AVG_EN
        int exp_p[3] = '{20, 30, 40};
`else
        int exp_p[3] = '{20, 40, 40};
`endif
        do_reset();
        meas_rdy = 1'b1;
        send(16000, 10);
        send(-16000, 10);
        send(16000, 20);
        send(-16000, 20);
        send(16000, 20);
        send(-16000, 20);
        send(16000, 1);
        idle(2);
        checks++;
        if (cap_q.size() != 3) begin
            fails++;
            $display("FAIL avg_count: got %0d emits expected 3", cap_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= cap_q.size()) begin
                fails++;
                $display("FAIL avg_emit%0d: missing, expected period %0d duty 2", i, exp_p[i]);
            end else if (cap_q[i].p !== 11'(exp_p[i]) || cap_q[i].d !== 2'd2) begin
                fails++;
                $display("FAIL avg_emit%0d: got period %0d duty %0d expected period %0d duty 2",
                         i, cap_q[i].p, cap_q[i].d, exp_p[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_hysteresis();
        test_valid_gaps();
        test_timeout();
        test_overrun();
        test_avg();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
